// File: rtl/weighted_rr_arbiter.sv
// -----------------------------------------------------------------------------
// weighted_rr_arbiter
//
// Weighted round-robin arbiter that shares one downstream resource among N
// requesters. Each requester has a programmable weight: the largest number of
// back-to-back transfers it may take per grant. A grant is held while `ready`
// is low and rotates fairly once it is released.
//
// Ports:
//   clk          rising-edge system clock
//   rst          synchronous, active-high reset
//   request[N]   per-requester request level
//   ready        resource accepts a transfer this cycle
//   weight_wr    write strobe for one weight register
//   weight_idx   target requester of the weight write
//   weight_data  new weight value (0 behaves as 1)
//   grant[N]     registered grant, one-hot or zero
//   grant_valid  |grant
//   grant_idx    binary index of the granted requester, 0 when idle
//   xfer         grant_valid & request[grant_idx] & ready (combinational)
//
// Optional build macro ARB_XFER_COUNT_EN adds:
//   count_clr        zero the transfer counter (wins over an increment)
//   xfer_count[16]   free-running transfer counter, wraps 0xFFFF -> 0
// -----------------------------------------------------------------------------
module weighted_rr_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned WW = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  request,
    input  logic          ready,
    input  logic          weight_wr,
    input  logic [IW-1:0] weight_idx,
    input  logic [WW-1:0] weight_data,
    output logic [N-1:0]  grant,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx,
    output logic          xfer
`ifdef ARB_XFER_COUNT_EN
    ,
    input  logic          count_clr,
    output logic [15:0]   xfer_count
`endif
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [N-1:0]  grant_n;
    logic [IW-1:0] owner_n;
    logic [WW-1:0] credit, credit_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [WW-1:0] weight [N];

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // Returns {found, index} of the first set bit of vec, scanning upward
    // from start and wrapping past N-1 back to 0.
    function automatic logic [IW:0] find_first(input logic [N-1:0]  vec,
                                               input logic [IW-1:0] start);
        logic          found;
        logic [IW-1:0] idx;
        int unsigned   j;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(start) + k) % N;
            if (!found && vec[IW'(j)]) begin
                found = 1'b1;
                idx   = IW'(j);
            end
        end
        return {found, idx};
    endfunction

    // A zero weight still grants one transfer.
    function automatic logic [WW-1:0] eff_weight(input logic [WW-1:0] w);
        return (w == '0) ? WW'(1) : w;
    endfunction

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] g);
        return (g == IW'(N - 1)) ? '0 : g + IW'(1);
    endfunction

    // -------------------------------------------------------------------------
    // Weight registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < N; i++) begin
                weight[i] <= WW'(1);
            end
        end else if (weight_wr && (32'(weight_idx) < N)) begin
            weight[weight_idx] <= weight_data;
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            credit    <= '0;
            ptr       <= '0;
        end else begin
            state     <= state_n;
            grant     <= grant_n;
            grant_idx <= owner_n;
            credit    <= credit_n;
            ptr       <= ptr_n;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    logic          exhausted;
    logic          release_g;
    logic [N-1:0]  cand;
    logic [IW:0]   pick;
    logic [IW-1:0] search_from;

    always_comb begin
        state_n     = state;
        grant_n     = grant;
        owner_n     = grant_idx;
        credit_n    = credit;
        ptr_n       = ptr;
        exhausted   = 1'b0;
        release_g   = 1'b0;
        cand        = request;
        search_from = ptr;
        pick        = '0;

        case (state)
            IDLE: begin
                pick = find_first(request, ptr);
                if (pick[IW]) begin
                    state_n  = GRANT;
                    grant_n  = N'(1) << pick[IW-1:0];
                    owner_n  = pick[IW-1:0];
                    credit_n = eff_weight(weight[pick[IW-1:0]]);
                end
            end

            GRANT: begin
                exhausted = xfer && (credit == WW'(1));
                // A dropped request is not a transfer, so no decrement here.
                release_g = exhausted || !request[grant_idx];
                if (release_g) begin
                    search_from = next_ptr(grant_idx);
                    ptr_n       = search_from;
                    // The owner may compete again only if it still has credit;
                    // as the sole requester it wraps round to itself.
                    if (exhausted) begin
                        cand[grant_idx] = 1'b0;
                        if (cand == '0 && request[grant_idx]) begin
                            cand[grant_idx] = 1'b1;
                        end
                    end
                    pick = find_first(cand, search_from);
                    if (pick[IW]) begin
                        grant_n  = N'(1) << pick[IW-1:0];
                        owner_n  = pick[IW-1:0];
                        credit_n = eff_weight(weight[pick[IW-1:0]]);
                    end else begin
                        state_n  = IDLE;
                        grant_n  = '0;
                        owner_n  = '0;
                        credit_n = '0;
                    end
                end else if (xfer) begin
                    credit_n = credit - WW'(1);
                end
            end

            default: begin
                state_n  = IDLE;
                grant_n  = '0;
                owner_n  = '0;
                credit_n = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        grant_valid = |grant;
        xfer        = grant_valid && request[grant_idx] && ready;
    end

`ifdef ARB_XFER_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst || count_clr) begin
            xfer_count <= '0;
        end else if (xfer) begin
            xfer_count <= xfer_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_weighted_rr_arbiter
//
// Directed bench for weighted_rr_arbiter (N=4, WW=4). Expected grants are
// queued as each step is driven and popped/compared one cycle at a time.
// Build with ARB_XFER_COUNT_EN defined to also exercise the transfer counter.
// -----------------------------------------------------------------------------
module tb_weighted_rr_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned WW = 4;
    localparam int unsigned IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  request;
    logic          ready;
    logic          weight_wr;
    logic [IW-1:0] weight_idx;
    logic [WW-1:0] weight_data;
    logic [N-1:0]  grant;
    logic          grant_valid;
    logic [IW-1:0] grant_idx;
    logic          xfer;
    logic          count_clr;
`ifdef ARB_XFER_COUNT_EN
    logic [15:0]   xfer_count;
`endif

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    logic [N-1:0] exp_q[$];

    weighted_rr_arbiter #(.N(N), .WW(WW), .IW(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .request     (request),
        .ready       (ready),
        .weight_wr   (weight_wr),
        .weight_idx  (weight_idx),
        .weight_data (weight_data),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .xfer        (xfer)
`ifdef ARB_XFER_COUNT_EN
        ,
        .count_clr   (count_clr),
        .xfer_count  (xfer_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] oh2idx(input logic [N-1:0] oh);
        logic [IW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (oh[i]) r = IW'(i);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock; compare outputs against the next queued grant (if any).
    task automatic tick();
        logic [N-1:0] eg;
        logic         ex;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            eg = exp_q.pop_front();
            ex = (|eg) && request[oh2idx(eg)] && ready;
            chk("grant",       32'(grant),       32'(eg));
            chk("grant_idx",   32'(grant_idx),   32'(oh2idx(eg)));
            chk("grant_valid", 32'(grant_valid), 32'(|eg));
            chk("xfer",        32'(xfer),        32'(ex));
        end
    endtask

    task automatic expect_ticks(input logic [N-1:0] g, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            exp_q.push_back(g);
            tick();
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        request = '0;
        ready   = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [IW-1:0] idx, input logic [WW-1:0] data);
        weight_idx  = idx;
        weight_data = data;
        weight_wr   = 1'b1;
        tick();
        weight_wr = 1'b0;
    endtask

    initial begin
        logic [IW-1:0] pat [7];
        pat = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};

        rst         = 1'b1;
        request     = '0;
        ready       = 1'b0;
        weight_wr   = 1'b0;
        weight_idx  = '0;
        weight_data = '0;
        count_clr   = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_grant",       32'(grant),       32'(0));
        chk("rst_grant_valid", 32'(grant_valid), 32'(0));
        chk("rst_grant_idx",   32'(grant_idx),   32'(0));
`ifdef ARB_XFER_COUNT_EN
        chk("rst_count", 32'(xfer_count), 32'(0));
`endif
        rst = 1'b0;

        // 1: strict rotation at weight 1, one-cycle latency
        request = 4'b1111;
        ready   = 1'b1;
        chk("t1_latency", 32'(grant), 32'(0));
        expect_ticks(4'b0001, 1);
        expect_ticks(4'b0010, 1);
        expect_ticks(4'b0100, 1);
        expect_ticks(4'b1000, 1);
        expect_ticks(4'b0001, 1);

        // 2: weights {1,3,1,2}
        do_reset();
        wr(2'd0, 4'd1);
        wr(2'd1, 4'd3);
        wr(2'd2, 4'd1);
        wr(2'd3, 4'd2);
        request = 4'b1111;
        ready   = 1'b1;
        for (int unsigned r = 0; r < 2; r++) begin
            for (int unsigned i = 0; i < 7; i++) begin
                expect_ticks(N'(1) << pat[i], 1);
            end
        end

        // 3: back-pressure mid-burst holds grant and credit
        do_reset();
        wr(2'd1, 4'd3);
        request = 4'b0110;
        ready   = 1'b1;
        expect_ticks(4'b0010, 2);
        ready = 1'b0;
        expect_ticks(4'b0010, 3);
        ready = 1'b1;
        expect_ticks(4'b0010, 1);
        expect_ticks(4'b0100, 1);

        // 4: owner drops request after one xfer; ptr moves past it
        do_reset();
        wr(2'd0, 4'd2);
        wr(2'd2, 4'd2);
        request = 4'b0101;
        ready   = 1'b1;
        expect_ticks(4'b0001, 2);
        request = 4'b0100;
        expect_ticks(4'b0100, 1);
        request = 4'b0000;
        expect_ticks(4'b0000, 1);
        request = 4'b1001;
        expect_ticks(4'b1000, 1);

        // 5: single requester re-granted with no gaps
        do_reset();
        wr(2'd3, 4'd2);
        request = 4'b1000;
        ready   = 1'b1;
        expect_ticks(4'b1000, 6);
        request = 4'b0000;
        expect_ticks(4'b0000, 1);

        // Weight 0 acts as 1
        do_reset();
        wr(2'd0, 4'd0);
        request = 4'b0011;
        ready   = 1'b1;
        expect_ticks(4'b0001, 1);
        expect_ticks(4'b0010, 1);
        expect_ticks(4'b0001, 1);

        // Writing the owner's weight leaves its running credit alone
        do_reset();
        wr(2'd0, 4'd3);
        request = 4'b0011;
        ready   = 1'b1;
        expect_ticks(4'b0001, 1);
        weight_idx  = 2'd0;
        weight_data = 4'd1;
        weight_wr   = 1'b1;
        expect_ticks(4'b0001, 1);
        weight_wr = 1'b0;
        expect_ticks(4'b0001, 1);
        expect_ticks(4'b0010, 1);
        expect_ticks(4'b0001, 1);
        expect_ticks(4'b0010, 1);

        // 6: reset mid-burst restores weights and clears grant
        do_reset();
        wr(2'd3, 4'd5);
        request = 4'b1000;
        ready   = 1'b1;
        expect_ticks(4'b1000, 2);
`ifdef ARB_XFER_COUNT_EN
        chk("cnt_before_rst", 32'(xfer_count), 32'(1));
`endif
        rst = 1'b1;
        expect_ticks(4'b0000, 1);
`ifdef ARB_XFER_COUNT_EN
        chk("cnt_after_rst", 32'(xfer_count), 32'(0));
`endif
        rst = 1'b0;
        expect_ticks(4'b1000, 1);
        request = 4'b1001;
        expect_ticks(4'b0001, 1);
`ifdef ARB_XFER_COUNT_EN
        chk("cnt_incr", 32'(xfer_count), 32'(1));
`endif
        count_clr = 1'b1;
        expect_ticks(4'b1000, 1);
`ifdef ARB_XFER_COUNT_EN
        chk("cnt_clr_priority", 32'(xfer_count), 32'(0));
`endif
        count_clr = 1'b0;
        expect_ticks(4'b0001, 1);
`ifdef ARB_XFER_COUNT_EN
        chk("cnt_after_clr", 32'(xfer_count), 32'(1));
`endif

        request = '0;
        ready   = 1'b0;
        tick();
        chk("queue_empty", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/weighted_rr_arbiter.md
Name: weighted_rr_arbiter

Overview:
Weighted round-robin arbiter that shares one downstream resource among N requesters. Each requester owns a programmable weight, which is the maximum number of back-to-back transfers it may take per grant. A grant is held across `ready` back-pressure and rotates fairly after release. It sits in front of the shared resource and replaces the plain round-robin arbiter where bandwidth shares must be unequal.

Parameters:
- N, 4, number of requesters (2..16).
- WW, 4, weight width in bits. Maximum burst is 2^WW-1 transfers.
- IW, $clog2(N), index width used for `weight_idx` and `grant_idx`.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- request  input  N  per-requester request level; bit i is requester i.
- ready  input  1  resource accepts a transfer this cycle.
- weight_wr  input  1  write strobe for one weight register.
- weight_idx  input  IW  target requester of the weight write.
- weight_data  input  WW  new weight value.
- grant  output  N  registered, one-hot or zero.
- grant_valid  output  1  equals |grant.
- grant_idx  output  IW  binary index of the granted requester; 0 when idle.
- xfer  output  1  combinational; high when grant_valid, request[grant_idx] and ready are all high.

Behaviour:
Reset values:
- grant=0, grant_valid=0, grant_idx=0.
- Rotation pointer ptr=0.
- All weights = 1.
- Credit counter = 0.
- State = IDLE.

States:
- IDLE: grant=0. If any request bit is high, select the first set bit searching from ptr upward with wrap-around. The next cycle enters GRANT with grant=onehot(sel) and credit=eff_weight(sel). With no requests, stay in IDLE.
- GRANT (owner g):
  - A transfer occurs when xfer=1; credit decrements by 1.
  - When ready=0, grant, credit and ptr all hold. No timeout applies.
  - Release condition: (xfer and credit==1) or request[g]==0.
  - On release: ptr becomes (g+1) mod N. Search from that new ptr over the current request vector, with g's bit masked out only if its credit is exhausted.
  - If a winner w is found, the next cycle grants w with credit reloaded from w's weight. There is no idle bubble between grants.
  - If no winner is found, the next cycle returns to IDLE with grant=0.
  - If g is the only requester and is still requesting after its credit is exhausted, it is re-granted next cycle with fresh credit.

Weight rules:
- eff_weight(i) = (weight[i]==0) ? 1 : weight[i].
- A weight write takes effect on the next edge.
- Writing the current owner's weight does not change its running credit; the new value applies from its next grant.

Grant latency:
- 1 cycle from request assertion in IDLE to grant.

Boundary conditions:
- Request dropping on the same cycle as ready=1 is not a transfer; release proceeds with no decrement.
- All N requesting at weight 1 gives a strict rotation of 0,1,2,...,N-1,0 with one grant per cycle.
- rst asserted mid-burst clears grant on the next edge. Weights return to 1 and ptr returns to 0.

Optional Feature:
ARB_XFER_COUNT_EN
- Defined:
  - Adds output xfer_count[15:0], which increments on every xfer and wraps at 0xFFFF to 0.
  - Adds input count_clr. count_clr zeroes the counter on the next edge and takes priority over an increment in the same cycle.
  - rst clears the counter.
- Undefined: neither port exists, no counter logic is built, and all other behaviour is identical.

Test Plan:
1. Reset then request=4'b1111, ready=1, all weights 1 -> grant sequence 0001, 0010, 0100, 1000, 0001, one per cycle; the first grant appears 1 cycle after request.
2. Weights {1,3,1,2} (index 0..3), request=4'b1111, ready=1 -> the grant_idx pattern over 7 cycles is 0, 1, 1, 1, 2, 3, 3, then it repeats.
3. Owner 1 with weight 3 and ready low for 3 cycles mid-burst -> grant stays 0010, credit holds, xfer=0. After ready returns, exactly 3 xfers in total occur before rotation to requester 2.
4. request=4'b0101, weights 2, then request[0] drops after 1 xfer -> immediate release next cycle, grant=0100, and ptr moves past 0.
5. Single requester 3, weight 2, request held -> grant 1000 continuously, credit reloads every 2 xfers, and no grant gaps appear. After request=0, grant=0 next cycle.
6. rst pulsed during a burst -> grant=0 the next cycle. A subsequent request=4'b1000 with weight 5 previously written is granted for only 1 xfer, because the weight was reset to 1. With ARB_XFER_COUNT_EN defined, xfer_count reads 0 after the reset.
